// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants, direction encoding and engine state types for snake_body_store
package snake_pkg;

    // Grid geometry: 64x48 cells of 10x10 pixels over a 640x480 frame.
    localparam int GRID_W = 64;
    localparam int GRID_H = 48;
    localparam int CELLS  = GRID_W * GRID_H;
    localparam int CELL_AW = 12;
    localparam logic [5:0]         GRID_X_MAX = 6'(GRID_W - 1);
    localparam logic [5:0]         GRID_Y_MAX = 6'(GRID_H - 1);
    localparam logic [CELL_AW-1:0] LAST_CELL  = CELL_AW'(CELLS - 1);

    // Pixel-space limits for the query path.
    localparam logic [9:0] PIX_W = 10'd640;
    localparam logic [9:0] PIX_H = 10'd480;

    // Body ring and initial snake.
    localparam int RING_DEPTH = 256;
    localparam int PTR_W      = 8;
    typedef logic [PTR_W-1:0] ptr_t;
    localparam logic [8:0] MAX_LEN  = 9'd256;
    localparam logic [8:0] INIT_LEN = 9'd4;
    localparam logic [5:0] INIT_X   = 6'd32;
    localparam logic [5:0] INIT_Y   = 6'd24;
    localparam logic [5:0] INIT_TAIL_X   = INIT_X - 6'(INIT_LEN - 9'd1);
    localparam ptr_t       INIT_LAST_IDX = ptr_t'(INIT_LEN - 9'd1);

    // Direction encoding; a reversal is exactly a two-bit flip.
    localparam logic [1:0] DIR_UP    = 2'b11;
    localparam logic [1:0] DIR_DOWN  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b01;

    typedef enum logic [2:0] {
        S_CLR, S_INIT, S_IDLE, S_TAIL, S_CHK, S_CHKW, S_HEAD, S_DEAD
    } state_t;

    // All engine state in one record so reset and restart share one value.
    typedef struct packed {
        state_t             state;
        logic [CELL_AW-1:0] clr_addr;
        logic [5:0]         head_x;
        logic [5:0]         head_y;
        logic [5:0]         nh_x;
        logic [5:0]         nh_y;
        logic [1:0]         dir;
        ptr_t               hptr;
        ptr_t               tptr;
        logic [8:0]         len;
        logic               grow_pend;
        logic               tick_pend;
        logic               grow_step;
    } eng_t;

    localparam eng_t ENG_RST = '{
        state:     S_CLR,
        clr_addr:  '0,
        head_x:    INIT_X,
        head_y:    INIT_Y,
        nh_x:      INIT_X,
        nh_y:      INIT_Y,
        dir:       DIR_RIGHT,
        hptr:      '0,
        tptr:      '0,
        len:       '0,
        grow_pend: 1'b0,
        tick_pend: 1'b0,
        grow_step: 1'b0
    };

    function automatic logic [CELL_AW-1:0] cell_addr(input logic [5:0] x, input logic [5:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/snake_body_store_if.sv
// rtl/snake_body_store_if.sv - pixel query bus between the VGA reader and the snake body store
// master: VGA side, drives iCoord_X/iCoord_Y, receives oHit two clocks later
// slave:  body store side
interface snake_query_if;
    import snake_pkg::*;

    logic [9:0] iCoord_X;
    logic [9:0] iCoord_Y;
    logic       oHit;

    modport master (output iCoord_X, output iCoord_Y, input oHit);
    modport slave  (input iCoord_X, input iCoord_Y, output oHit);
endinterface

// File: rtl/snake_bitmap_ram.sv
// rtl/snake_bitmap_ram.sv - 3072x1 true-dual-port synchronous occupancy RAM
// iCLK      : clock
// addr_a_i  : port A read address (query path), q_a_o registered read data
// addr_b_i  : port B address (engine), we_b_i/din_b_i write, q_b_o registered read data
// Both ports return the data held before any same-cycle write.
module snake_bitmap_ram
    import snake_pkg::*;
(
    input  logic               iCLK,
    input  logic [CELL_AW-1:0] addr_a_i,
    output logic               q_a_o,
    input  logic [CELL_AW-1:0] addr_b_i,
    input  logic               we_b_i,
    input  logic               din_b_i,
    output logic               q_b_o
);

    logic mem [CELLS];

    always_ff @(posedge iCLK) begin
        q_a_o <= mem[addr_a_i];
    end

    always_ff @(posedge iCLK) begin
        if (we_b_i) begin
            mem[addr_b_i] <= din_b_i;
        end
        q_b_o <= mem[addr_b_i];
    end

endmodule

// File: rtl/snake_body_store.sv
// rtl/snake_body_store.sv - snake body engine with occupancy bitmap and fixed-latency pixel hit query
// iCLK, iRST_N          : clock, asynchronous active-low reset
// iTick, iDir           : move pulse and requested direction
// iGrow, iRestart       : grow request pulse, re-initialise pulse
// qry (slave)           : pixel query coordinates in, oHit out after two clocks
// oHead_X/oHead_Y       : head cell, oLength : body length
// oDead, oBusy          : collision flag, clear/init/step in progress
module snake_body_store
    import snake_pkg::*;
(
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic         iTick,
    input  logic [1:0]   iDir,
    input  logic         iGrow,
    input  logic         iRestart,
    snake_query_if.slave qry,
    output logic [5:0]   oHead_X,
    output logic [5:0]   oHead_Y,
    output logic [8:0]   oLength,
    output logic         oDead,
    output logic         oBusy
);

    eng_t eng_q, eng_d;

    logic [CELL_AW-1:0] ring_q [RING_DEPTH];
    logic               ring_we;
    logic [CELL_AW-1:0] ring_wdata;
    logic [CELL_AW-1:0] tail_cell;

    logic               bm_we;
    logic               bm_din;
    logic               bm_dout;
    logic [CELL_AW-1:0] bm_addr;

    logic [1:0]         step_dir;
    logic [5:0]         step_x;
    logic [5:0]         step_y;
    logic               step_wall;

    logic               init_active;
    logic [5:0]         cx_d, cx_q;
    logic [5:0]         cy_d, cy_q;
    logic               oor_d, oor_q;
    logic               oor2_q;
    logic               init2_q;
    logic               hit_a;

    // ------------------------------------------------------------------
    // Query pipeline: stage 1 divides by 10 via *205>>11, stage 2 is the
    // RAM read. Runs every cycle whatever the engine is doing.
    // ------------------------------------------------------------------
    assign cx_d  = 6'((18'(qry.iCoord_X) * 18'd205) >> 11);
    assign cy_d  = 6'((18'(qry.iCoord_Y) * 18'd205) >> 11);
    assign oor_d = (qry.iCoord_X >= PIX_W) || (qry.iCoord_Y >= PIX_H);

    // Restart counts as init so a stale bitmap never leaks out during the clear.
    assign init_active = (eng_q.state == S_CLR) || (eng_q.state == S_INIT) || iRestart;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cx_q    <= '0;
            cy_q    <= '0;
            oor_q   <= 1'b0;
            oor2_q  <= 1'b0;
            init2_q <= 1'b1;
        end else begin
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            oor_q   <= oor_d;
            oor2_q  <= oor_q;
            init2_q <= init_active;
        end
    end

    assign qry.oHit = hit_a & ~oor2_q & ~init2_q;

    snake_bitmap_ram u_bitmap (
        .iCLK     (iCLK),
        .addr_a_i (cell_addr(cx_q, cy_q)),
        .q_a_o    (hit_a),
        .addr_b_i (bm_addr),
        .we_b_i   (bm_we),
        .din_b_i  (bm_din),
        .q_b_o    (bm_dout)
    );

    // ------------------------------------------------------------------
    // Body ring: written only at the head pointer, read at the tail.
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (ring_we) begin
            ring_q[eng_q.hptr] <= ring_wdata;
        end
    end

    assign tail_cell = ring_q[eng_q.tptr];

    // ------------------------------------------------------------------
    // Candidate next head. A request that flips both direction bits is a
    // reversal and keeps the current heading.
    // ------------------------------------------------------------------
    always_comb begin
        step_dir  = ((iDir ^ eng_q.dir) == 2'b11) ? eng_q.dir : iDir;
        step_x    = eng_q.head_x;
        step_y    = eng_q.head_y;
        step_wall = 1'b0;
        case (step_dir)
            DIR_UP: begin
                if (eng_q.head_y == 6'd0) step_wall = 1'b1;
                else                      step_y    = eng_q.head_y - 6'd1;
            end
            DIR_DOWN: begin
                if (eng_q.head_y == GRID_Y_MAX) step_wall = 1'b1;
                else                            step_y    = eng_q.head_y + 6'd1;
            end
            DIR_LEFT: begin
                if (eng_q.head_x == 6'd0) step_wall = 1'b1;
                else                      step_x    = eng_q.head_x - 6'd1;
            end
            default: begin
                if (eng_q.head_x == GRID_X_MAX) step_wall = 1'b1;
                else                            step_x    = eng_q.head_x + 6'd1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) eng_q <= ENG_RST;
        else         eng_q <= eng_d;
    end

    always_comb begin
        eng_d      = eng_q;
        bm_we      = 1'b0;
        bm_din     = 1'b0;
        bm_addr    = cell_addr(eng_q.nh_x, eng_q.nh_y);
        ring_we    = 1'b0;
        ring_wdata = cell_addr(eng_q.nh_x, eng_q.nh_y);

        // Ticks arriving mid-step are remembered once; extras are lost.
        if (iTick && (eng_q.state != S_IDLE) && (eng_q.state != S_DEAD)) begin
            eng_d.tick_pend = 1'b1;
        end
        if (iGrow) begin
            eng_d.grow_pend = 1'b1;
        end

        case (eng_q.state)
            S_CLR: begin
                bm_we          = 1'b1;
                bm_addr        = eng_q.clr_addr;
                eng_d.clr_addr = eng_q.clr_addr + 1'b1;
                if (eng_q.clr_addr == LAST_CELL) begin
                    eng_d.state = S_INIT;
                end
            end
            S_INIT: begin
                // hptr doubles as the init index; ends pointing past the head.
                bm_we      = 1'b1;
                bm_din     = 1'b1;
                bm_addr    = cell_addr(INIT_TAIL_X + eng_q.hptr[5:0], INIT_Y);
                ring_we    = 1'b1;
                ring_wdata = bm_addr;
                eng_d.hptr = eng_q.hptr + 1'b1;
                if (eng_q.hptr == INIT_LAST_IDX) begin
                    eng_d.len   = INIT_LEN;
                    eng_d.state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (iTick || eng_q.tick_pend) begin
                    eng_d.tick_pend = 1'b0;
                    eng_d.dir       = step_dir;
                    eng_d.nh_x      = step_x;
                    eng_d.nh_y      = step_y;
                    if (step_wall) begin
                        eng_d.state = S_DEAD;
                    end else if (eng_q.grow_pend && (eng_q.len < MAX_LEN)) begin
                        eng_d.grow_step = 1'b1;
                        eng_d.state     = S_CHK;
                    end else begin
                        eng_d.grow_step = 1'b0;
                        // Growth refused at full length is simply dropped.
                        if (eng_q.grow_pend) eng_d.grow_pend = iGrow;
                        eng_d.state = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                // Vacate the tail first so the head may move into it.
                bm_we       = 1'b1;
                bm_din      = 1'b0;
                bm_addr     = tail_cell;
                eng_d.tptr  = eng_q.tptr + 1'b1;
                eng_d.state = S_CHK;
            end
            S_CHK: begin
                eng_d.state = S_CHKW;
            end
            S_CHKW: begin
                eng_d.state = bm_dout ? S_DEAD : S_HEAD;
            end
            S_HEAD: begin
                bm_we        = 1'b1;
                bm_din       = 1'b1;
                ring_we      = 1'b1;
                eng_d.hptr   = eng_q.hptr + 1'b1;
                eng_d.head_x = eng_q.nh_x;
                eng_d.head_y = eng_q.nh_y;
                if (eng_q.grow_step) begin
                    eng_d.len       = eng_q.len + 1'b1;
                    eng_d.grow_pend = iGrow;
                end
                eng_d.state = S_IDLE;
            end
            S_DEAD: begin
                eng_d.tick_pend = 1'b0;
            end
            default: begin
                eng_d.state = S_CLR;
            end
        endcase

        if (iRestart) begin
            eng_d   = ENG_RST;
            bm_we   = 1'b0;
            ring_we = 1'b0;
        end
    end

    assign oHead_X = eng_q.head_x;
    assign oHead_Y = eng_q.head_y;
    assign oLength = eng_q.len;
    assign oDead   = (eng_q.state == S_DEAD);
    assign oBusy   = (eng_q.state != S_IDLE) && (eng_q.state != S_DEAD);

endmodule

// File: tb/tb_snake_body_store.sv
// tb/tb_snake_body_store.sv - randomized self-checking bench for snake_body_store
module tb_snake_body_store;

    localparam logic [1:0] D_UP    = 2'b11;
    localparam logic [1:0] D_DOWN  = 2'b00;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b01;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iTick = 1'b0;
    logic [1:0] iDir = D_RIGHT;
    logic       iGrow = 1'b0;
    logic       iRestart = 1'b0;
    logic [5:0] oHead_X, oHead_Y;
    logic [8:0] oLength;
    logic       oDead, oBusy;

    snake_query_if qif ();

    snake_body_store dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iTick    (iTick),
        .iDir     (iDir),
        .iGrow    (iGrow),
        .iRestart (iRestart),
        .qry      (qif),
        .oHead_X  (oHead_X),
        .oHead_Y  (oHead_Y),
        .oLength  (oLength),
        .oDead    (oDead),
        .oBusy    (oBusy)
    );

    always #5 iCLK = ~iCLK;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: body as a queue of cells, occupancy as a 2D array.
    bit         occ [64][48];
    int         bq_x[$];
    int         bq_y[$];
    int         m_hx, m_hy, m_len;
    bit         m_dead, m_grow;
    logic [1:0] m_dir;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            D_UP:    return D_DOWN;
            D_DOWN:  return D_UP;
            D_LEFT:  return D_RIGHT;
            default: return D_LEFT;
        endcase
    endfunction

    function automatic bit m_hit(input int x, input int y);
        if (x >= 640 || y >= 480) return 1'b0;
        return occ[x/10][y/10];
    endfunction

    task automatic model_init();
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 48; y++) occ[x][y] = 1'b0;
        bq_x.delete();
        bq_y.delete();
        for (int i = 0; i < 4; i++) begin
            bq_x.push_back(29 + i);
            bq_y.push_back(24);
            occ[29 + i][24] = 1'b1;
        end
        m_hx = 32; m_hy = 24; m_len = 4;
        m_dead = 1'b0; m_grow = 1'b0; m_dir = D_RIGHT;
    endtask

    // Returns the expected busy duration for a surviving step, -1 otherwise.
    task automatic model_step(input logic [1:0] d, output int exp_cyc);
        int nx, ny;
        bit grow;
        exp_cyc = -1;
        if (m_dead) return;
        if (d != opposite(m_dir)) m_dir = d;
        nx = m_hx; ny = m_hy;
        case (m_dir)
            D_UP:    ny = ny - 1;
            D_DOWN:  ny = ny + 1;
            D_LEFT:  nx = nx - 1;
            default: nx = nx + 1;
        endcase
        if (nx < 0 || nx >= 64 || ny < 0 || ny >= 48) begin
            m_dead = 1'b1;
            return;
        end
        grow = m_grow && (m_len < 256);
        if (m_grow && !grow) m_grow = 1'b0;
        if (!grow) begin
            occ[bq_x[0]][bq_y[0]] = 1'b0;
            bq_x.delete(0);
            bq_y.delete(0);
        end
        if (occ[nx][ny]) begin
            m_dead = 1'b1;
            return;
        end
        occ[nx][ny] = 1'b1;
        bq_x.push_back(nx);
        bq_y.push_back(ny);
        m_hx = nx; m_hy = ny;
        if (grow) begin
            m_len  = m_len + 1;
            m_grow = 1'b0;
        end
        exp_cyc = grow ? 3 : 4;
    endtask

    // Optional grow pulse, one tick, then wait for the engine to settle.
    task automatic do_step(input logic [1:0] d, input bit g, output int cyc, output int exp_cyc);
        if (g) begin
            @(negedge iCLK); iGrow = 1'b1;
            @(negedge iCLK); iGrow = 1'b0;
            m_grow = 1'b1;
        end
        @(negedge iCLK); iDir = d; iTick = 1'b1;
        @(negedge iCLK); iTick = 1'b0;
        cyc = 0;
        while (oBusy === 1'b1 && cyc < 40) begin
            @(negedge iCLK);
            cyc++;
        end
        n_tot++;
        if (cyc >= 40) $display("FAIL step_timeout: busy for %0d cycles, limit 40", cyc);
        else n_pass++;
        model_step(d, exp_cyc);
    endtask

    task automatic query(input int x, input int y, output logic h);
        @(negedge iCLK);
        qif.iCoord_X = 10'(x);
        qif.iCoord_Y = 10'(y);
        repeat (2) @(negedge iCLK);
        h = qif.oHit;
    endtask

    task automatic wait_ready();
        int cnt = 0;
        while (oBusy === 1'b1 && cnt < 3072 + 4 + 4) begin
            @(negedge iCLK);
            cnt++;
        end
        n_tot++;
        if (oBusy !== 1'b0) $display("FAIL init_timeout: oBusy=%b after %0d cycles, required 0", oBusy, cnt);
        else n_pass++;
    endtask

    task automatic do_restart();
        @(negedge iCLK); iRestart = 1'b1;
        @(negedge iCLK); iRestart = 1'b0;
        model_init();
    endtask

    task automatic test_reset();
        logic h;
        iRST_N = 1'b0;
        qif.iCoord_X = 10'd320;
        qif.iCoord_Y = 10'd240;
        repeat (3) @(negedge iCLK);
        n_tot++; if (oBusy !== 1'b1)   $display("FAIL rst_busy: got %b expected 1", oBusy); else n_pass++;
        n_tot++; if (oLength !== 9'd0) $display("FAIL rst_len: got %0d expected 0", oLength); else n_pass++;
        n_tot++; if (oHead_X !== 6'd32 || oHead_Y !== 6'd24)
            $display("FAIL rst_head: got (%0d,%0d) expected (32,24)", oHead_X, oHead_Y); else n_pass++;
        n_tot++; if (oDead !== 1'b0)   $display("FAIL rst_dead: got %b expected 0", oDead); else n_pass++;
        n_tot++; if (qif.oHit !== 1'b0) $display("FAIL rst_hit: got %b expected 0", qif.oHit); else n_pass++;
        iRST_N = 1'b1;
        model_init();
        query(320, 240, h);
        n_tot++; if (h !== 1'b0) $display("FAIL hit_during_clear: got %b expected 0", h); else n_pass++;
        wait_ready();
        n_tot++; if (oLength !== 9'd4) $display("FAIL init_len: got %0d expected 4", oLength); else n_pass++;
        n_tot++; if (oHead_X !== 6'd32 || oHead_Y !== 6'd24)
            $display("FAIL init_head: got (%0d,%0d) expected (32,24)", oHead_X, oHead_Y); else n_pass++;
        query(320, 240, h);
        n_tot++; if (h !== 1'b1) $display("FAIL q_320_240: got %b expected 1", h); else n_pass++;
        query(290, 245, h);
        n_tot++; if (h !== 1'b1) $display("FAIL q_290_245: got %b expected 1", h); else n_pass++;
        query(280, 240, h);
        n_tot++; if (h !== 1'b0) $display("FAIL q_280_240: got %b expected 0", h); else n_pass++;
        query(650, 10, h);
        n_tot++; if (h !== 1'b0) $display("FAIL q_650_10: got %b expected 0", h); else n_pass++;
    endtask

    task automatic test_step_grow_reverse();
        int cyc, ec;
        logic h;
        do_step(D_RIGHT, 1'b0, cyc, ec);
        n_tot++; if (oHead_X !== 6'd33 || oHead_Y !== 6'd24)
            $display("FAIL step_head: got (%0d,%0d) expected (33,24)", oHead_X, oHead_Y); else n_pass++;
        n_tot++; if (oLength !== 9'd4) $display("FAIL step_len: got %0d expected 4", oLength); else n_pass++;
        n_tot++; if (cyc !== 4) $display("FAIL step_busy: got %0d cycles expected 4", cyc); else n_pass++;
        query(330, 245, h);
        n_tot++; if (h !== 1'b1) $display("FAIL q_330_245: got %b expected 1", h); else n_pass++;
        query(290, 240, h);
        n_tot++; if (h !== 1'b0) $display("FAIL q_290_240: got %b expected 0", h); else n_pass++;

        do_step(D_RIGHT, 1'b1, cyc, ec);
        n_tot++; if (oHead_X !== 6'd34) $display("FAIL grow_head: got %0d expected 34", oHead_X); else n_pass++;
        n_tot++; if (oLength !== 9'd5) $display("FAIL grow_len: got %0d expected 5", oLength); else n_pass++;
        n_tot++; if (cyc !== 3) $display("FAIL grow_busy: got %0d cycles expected 3", cyc); else n_pass++;
        query(305, 245, h);
        n_tot++; if (h !== 1'b1) $display("FAIL grow_keeps_tail: got %b expected 1", h); else n_pass++;

        do_step(D_LEFT, 1'b0, cyc, ec);
        n_tot++; if (oHead_X !== 6'd35 || oHead_Y !== 6'd24)
            $display("FAIL reverse_head: got (%0d,%0d) expected (35,24)", oHead_X, oHead_Y); else n_pass++;
        n_tot++; if (oDead !== 1'b0) $display("FAIL reverse_dead: got %b expected 0", oDead); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_restart();
        wait_ready();
        @(negedge iCLK); iDir = D_RIGHT; iTick = 1'b1;
        @(negedge iCLK);
        @(negedge iCLK);
        @(negedge iCLK); iTick = 1'b0;
        repeat (20) @(negedge iCLK);
        n_tot++; if (oHead_X !== 6'd34 || oHead_Y !== 6'd24)
            $display("FAIL b2b_head: got (%0d,%0d) expected (34,24)", oHead_X, oHead_Y); else n_pass++;
        n_tot++; if (oLength !== 9'd4) $display("FAIL b2b_len: got %0d expected 4", oLength); else n_pass++;
    endtask

    task automatic test_wall();
        int cyc, ec, bad;
        logic h;
        do_restart();
        query(320, 240, h);
        n_tot++; if (h !== 1'b0) $display("FAIL restart_hit_masked: got %b expected 0", h); else n_pass++;
        wait_ready();
        for (int i = 0; i < 31; i++) do_step(D_RIGHT, 1'b0, cyc, ec);
        n_tot++; if (oHead_X !== 6'd63 || oDead !== 1'b0)
            $display("FAIL wall_edge: got x=%0d dead=%b expected x=63 dead=0", oHead_X, oDead); else n_pass++;
        do_step(D_RIGHT, 1'b0, cyc, ec);
        n_tot++; if (oDead !== 1'b1) $display("FAIL wall_dead: got %b expected 1", oDead); else n_pass++;
        n_tot++; if (oHead_X !== 6'd63) $display("FAIL wall_head: got %0d expected 63", oHead_X); else n_pass++;
        do_step(D_UP, 1'b0, cyc, ec);
        n_tot++; if (oHead_X !== 6'd63 || oHead_Y !== 6'd24 || oDead !== 1'b1)
            $display("FAIL dead_ignores_tick: got (%0d,%0d) dead=%b expected (63,24) dead=1",
                     oHead_X, oHead_Y, oDead); else n_pass++;
        bad = 0;
        for (int x = 56; x < 64; x++) begin
            query(x * 10 + 5, 245, h);
            if (h !== m_hit(x * 10 + 5, 245)) bad++;
        end
        n_tot++; if (bad != 0) $display("FAIL wall_bitmap_frozen: got %0d wrong cells expected 0", bad); else n_pass++;
        do_restart();
        wait_ready();
        n_tot++; if (oDead !== 1'b0 || oLength !== 9'd4 || oHead_X !== 6'd32)
            $display("FAIL restart_reinit: got dead=%b len=%0d x=%0d expected dead=0 len=4 x=32",
                     oDead, oLength, oHead_X); else n_pass++;
    endtask

    task automatic test_loop();
        int cyc, ec;
        logic [1:0] lap [4];
        lap[0] = D_UP; lap[1] = D_LEFT; lap[2] = D_DOWN; lap[3] = D_RIGHT;
        do_restart();
        wait_ready();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) do_step(lap[i], 1'b0, cyc, ec);
        n_tot++; if (oDead !== 1'b0) $display("FAIL loop4_dead: got %b expected 0", oDead); else n_pass++;
        n_tot++; if (oHead_X !== 6'd32 || oHead_Y !== 6'd24)
            $display("FAIL loop4_head: got (%0d,%0d) expected (32,24)", oHead_X, oHead_Y); else n_pass++;
        do_restart();
        wait_ready();
        do_step(D_RIGHT, 1'b1, cyc, ec);
        for (int i = 0; i < 3; i++) do_step(lap[i], 1'b0, cyc, ec);
        n_tot++; if (oDead !== 1'b1) $display("FAIL loop5_dead: got %b expected 1", oDead); else n_pass++;
        n_tot++; if (oDead !== m_dead) $display("FAIL loop5_model: got %b expected %b", oDead, m_dead); else n_pass++;
    endtask

    task automatic test_random();
        int cyc, ec, x, y, k;
        bit e;
        bit ex[$];
        for (int t = 0; t < 4; t++) begin
            do_restart();
            wait_ready();
            for (int s = 0; s < 80 && !m_dead; s++) begin
                do_step(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), cyc, ec);
                n_tot++; if (oHead_X !== 6'(m_hx) || oHead_Y !== 6'(m_hy))
                    $display("FAIL rnd_head: got (%0d,%0d) expected (%0d,%0d)", oHead_X, oHead_Y, m_hx, m_hy);
                else n_pass++;
                n_tot++; if (oLength !== 9'(m_len)) $display("FAIL rnd_len: got %0d expected %0d", oLength, m_len);
                else n_pass++;
                n_tot++; if (oDead !== m_dead) $display("FAIL rnd_dead: got %b expected %b", oDead, m_dead);
                else n_pass++;
                if (ec > 0) begin
                    n_tot++; if (cyc !== ec) $display("FAIL rnd_busy: got %0d cycles expected %0d", cyc, ec);
                    else n_pass++;
                end
                if ((s % 8) == 7 || m_dead) begin
                    // Back-to-back queries, one per clock, checked two clocks later.
                    ex.delete();
                    for (int i = 0; i < 10; i++) begin
                        @(negedge iCLK);
                        if (i >= 2) begin
                            e = ex.pop_front();
                            n_tot++; if (qif.oHit !== e) $display("FAIL rnd_hit: got %b expected %b", qif.oHit, e);
                            else n_pass++;
                        end
                        if (i < 8) begin
                            if ($urandom_range(0, 1) == 1) begin
                                k = $urandom_range(0, bq_x.size() - 1);
                                x = bq_x[k] * 10 + $urandom_range(0, 9);
                                y = bq_y[k] * 10 + $urandom_range(0, 9);
                            end else begin
                                x = $urandom_range(0, 700);
                                y = $urandom_range(0, 520);
                            end
                            qif.iCoord_X = 10'(x);
                            qif.iCoord_Y = 10'(y);
                            ex.push_back(m_hit(x, y));
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        qif.iCoord_X = 10'd0;
        qif.iCoord_Y = 10'd0;
        test_reset();
        test_step_grow_reverse();
        test_back_to_back();
        test_wall();
        test_loop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
